am_class_inference_ctrl: RTL
============================

Name: am_class_inference_ctrl

Overview:
- Sequencer and argmax stage on the consuming side of the associative-memory similarity accumulator.
- Per inference it does three things:
  - Drives the accumulator's control pair (comparing_query_hv_with_class_hv, inferring_class).
  - Steps the class-HV chunk and class addresses that feed the AND array.
  - Samples each class's final similarity_value and keeps a running maximum.
- Reports the winning class index and its similarity with a one-cycle done pulse.

Parameters:
- NUM_CLASSES, 26: number of class HVs in associative memory (>=1).
- CHUNKS_PER_HV, 10: chunks per HV, 500 dims each (>=1).
- SIM_WIDTH, 13: width of similarity_value.
- CLASS_W, $clog2(NUM_CLASSES) (min 1): class index width.
- CHUNK_W, $clog2(CHUNKS_PER_HV) (min 1): chunk index width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin inference; sampled only in IDLE.
- similarity_value  in  SIM_WIDTH  accumulator output.
- comparing_query_hv_with_class_hv  out  1  accumulator add enable.
- inferring_class  out  1  accumulator hold.
- class_addr  out  CLASS_W  class HV being compared.
- chunk_addr  out  CHUNK_W  chunk of class/query HV being compared.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; results valid.
- predicted_class  out  CLASS_W  argmax class index.
- max_similarity  out  SIM_WIDTH  similarity of predicted_class.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0. state = IDLE.
  - Internal best_val and best_idx are 0.
  - Reset during any state aborts the inference. The next cycle is IDLE with all outputs 0, and predicted_class/max_similarity are cleared.
- Addressing: AND-array data for (class_addr, chunk_addr) is valid in the same cycle (combinational memory read). The accumulator adds it on that cycle's edge.
- FSM states: IDLE, COMPARE, EVAL, CLEAR, DONE. Outputs are registered and decoded from state.
- IDLE:
  - Both control outputs 0; class_addr = 0, chunk_addr = 0.
  - start=1 -> COMPARE.
- COMPARE:
  - comparing_query_hv_with_class_hv = 1, inferring_class = 0.
  - chunk_addr counts 0 .. CHUNKS_PER_HV-1, one step per cycle.
  - After chunk CHUNKS_PER_HV-1 -> EVAL, with chunk_addr back to 0.
- EVAL:
  - comparing = 0, inferring_class = 1, so the accumulator holds the full class sum.
  - Compare similarity_value against best_val:
    - class_addr == 0: load best_val/best_idx unconditionally.
    - Otherwise load only if strictly greater, so ties keep the lower class index.
  - class_addr < NUM_CLASSES-1 -> CLEAR.
  - Otherwise -> DONE.
- CLEAR:
  - Both control outputs 0, so the accumulator zeroes.
  - class_addr increments; -> COMPARE.
- DONE:
  - Both control outputs 0, which also clears the accumulator. done = 1 for this cycle only.
  - predicted_class/max_similarity take best_idx/best_val, including the EVAL result of the last class, and are visible in the same cycle as done.
  - class_addr returns to 0; -> IDLE.
- Result outputs hold their values until the next DONE or reset. They do not change during a subsequent inference.
- Latency: start sampled at edge t puts COMPARE in cycle t+1. done is high in cycle t + NUM_CLASSES*(CHUNKS_PER_HV+2). Defaults: 312 cycles.
- The accumulator is never enabled for add and hold in the same cycle.
- No back-to-back overlap: start is ignored while busy (states COMPARE, EVAL, CLEAR, DONE). start held high in IDLE after DONE begins a new inference on the next edge.
- Degenerate sizes:
  - NUM_CLASSES = 1: EVAL -> DONE; predicted_class = 0.
  - CHUNKS_PER_HV = 1: COMPARE lasts one cycle.
- Widths: comparisons are unsigned on SIM_WIDTH bits. No wrap handling is needed; max sum is 5000 < 2^13.

Test Plan:
- Full inference with defaults: pulse start; the bench's accumulator model produces class sums with class 7 = 4100 and all others < 3000 -> done exactly 312 cycles after the start edge; predicted_class = 7, max_similarity = 4100; done high for exactly 1 cycle.
- Tie handling: classes 3 and 12 both sum to 2500, all others lower -> predicted_class = 3. Class 0 alone highest at 1 -> predicted_class = 0, max_similarity = 1.
- Control-pair protocol: monitor each class period -> exactly 10 cycles of comparing=1 with chunk_addr 0..9, then 1 cycle of inferring_class=1, then 1 cycle with both 0; never both 1; the accumulator reads 0 at the start of each class.
- start while busy: pulse start at cycles 5, 100 and 312 of an inference -> ignored; done count = 1; results unchanged. A start after return to IDLE launches a second inference, and the first result holds until the second done.
- Reset mid-operation: assert rst in EVAL of class 4 -> next cycle all outputs 0, state IDLE. A fresh start then completes normally in 312 cycles with the correct argmax.
- Degenerate parameters: NUM_CLASSES=1, CHUNKS_PER_HV=1 -> done 3 cycles after start; predicted_class = 0; max_similarity equals the single sum.

Source files
------------

// File: rtl/am_class_inference_ctrl.sv
// Sequencer and argmax stage for the associative-memory similarity accumulator.
// Walks every class HV chunk by chunk, then reports the best-matching class.
module am_class_inference_ctrl #(
    parameter int unsigned NUM_CLASSES   = 26,
    parameter int unsigned CHUNKS_PER_HV = 10,
    parameter int unsigned SIM_WIDTH     = 13,
    parameter int unsigned CLASS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    parameter int unsigned CHUNK_W       = (CHUNKS_PER_HV > 1) ? $clog2(CHUNKS_PER_HV) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SIM_WIDTH-1:0] similarity_value,
    output logic                 comparing_query_hv_with_class_hv,
    output logic                 inferring_class,
    output logic [CLASS_W-1:0]   class_addr,
    output logic [CHUNK_W-1:0]   chunk_addr,
    output logic                 busy,
    output logic                 done,
    output logic [CLASS_W-1:0]   predicted_class,
    output logic [SIM_WIDTH-1:0] max_similarity
);

    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS_PER_HV - 1);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        EVAL,
        CLEAR,
        DONE
    } state_t;

    state_t               state;
    logic [SIM_WIDTH-1:0] best_val;
    logic [CLASS_W-1:0]   best_idx;

    logic                 take_c;
    logic [SIM_WIDTH-1:0] next_best_val_c;
    logic [CLASS_W-1:0]   next_best_idx_c;

    // Running argmax: class 0 seeds it, later classes must be strictly larger.
    always_comb begin
        take_c          = (class_addr == '0) || (similarity_value > best_val);
        next_best_val_c = best_val;
        next_best_idx_c = best_idx;
        if (take_c) begin
            next_best_val_c = similarity_value;
            next_best_idx_c = class_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                            <= IDLE;
            comparing_query_hv_with_class_hv <= 1'b0;
            inferring_class                  <= 1'b0;
            class_addr                       <= '0;
            chunk_addr                       <= '0;
            busy                             <= 1'b0;
            done                             <= 1'b0;
            predicted_class                  <= '0;
            max_similarity                   <= '0;
            best_val                         <= '0;
            best_idx                         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state                            <= COMPARE;
                        comparing_query_hv_with_class_hv <= 1'b1;
                        busy                             <= 1'b1;
                        class_addr                       <= '0;
                        chunk_addr                       <= '0;
                    end
                end
                COMPARE: begin
                    if (chunk_addr == LAST_CHUNK) begin
                        state                            <= EVAL;
                        comparing_query_hv_with_class_hv <= 1'b0;
                        inferring_class                  <= 1'b1;
                        chunk_addr                       <= '0;
                    end else begin
                        chunk_addr <= chunk_addr + CHUNK_W'(1);
                    end
                end
                EVAL: begin
                    inferring_class <= 1'b0;
                    best_val        <= next_best_val_c;
                    best_idx        <= next_best_idx_c;
                    if (class_addr < LAST_CLASS) begin
                        state <= CLEAR;
                    end else begin
                        // Results go out with done, including this last class.
                        state           <= DONE;
                        done            <= 1'b1;
                        predicted_class <= next_best_idx_c;
                        max_similarity  <= next_best_val_c;
                    end
                end
                CLEAR: begin
                    state                            <= COMPARE;
                    comparing_query_hv_with_class_hv <= 1'b1;
                    class_addr                       <= class_addr + CLASS_W'(1);
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    class_addr <= '0;
                end
                default: begin
                    state                            <= IDLE;
                    comparing_query_hv_with_class_hv <= 1'b0;
                    inferring_class                  <= 1'b0;
                    busy                             <= 1'b0;
                    class_addr                       <= '0;
                    chunk_addr                       <= '0;
                end
            endcase
        end
    end

endmodule
